// File: rtl/riscv32s_pkg.sv
// ---------------------------------------------------------------------------
// riscv32s_pkg
// Shared definitions for the riscv32s subsystem blocks.
//   dump_state_e     : state encoding of the end-of-program RAM dump FSM
//   WORD_W           : data word width of the core/data RAM
//   RAMDEPTH_DEFAULT : default data RAM depth in words
//   addr_width()     : word-address width for a given RAM depth (min 1 bit)
// ---------------------------------------------------------------------------
package riscv32s_pkg;

  localparam int WORD_W           = 32;
  localparam int RAMDEPTH_DEFAULT = 256;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,  // core running, watching pc
    ST_DRAIN   = 3'd1,  // core frozen, last store retiring
    ST_ISSUE   = 3'd2,  // RAM read issued for idx
    ST_CAPTURE = 3'd3,  // RAM read data captured into dump registers
    ST_SEND    = 3'd4,  // word offered on the dump port
    ST_DONE    = 3'd5   // every word delivered; terminal
  } dump_state_e;

  // A depth of 1 would give a zero-width address; keep at least one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_dump_unit.sv
// ---------------------------------------------------------------------------
// ram_dump_unit
// End-of-program detector and data-RAM unloader. While the core runs, the
// word PC is compared against the program length; once it reaches it the
// core is frozen, then every data-RAM word 0..RAMDEPTH-1 is read in order and
// streamed as (index, data) over a valid/ready port.
//
// Ports
//   clock       in   single clock, all logic on its rising edge
//   reset       in   synchronous, active-high; wins over everything
//   pc          in   core program address (byte address)
//   prog_len    in   program length in instructions, watched only while running
//   core_halt   out  freeze request to the core (sticky until reset)
//   ram_rden    out  data RAM read enable, high only while issuing a read
//   ram_addr    out  data RAM word address, 0 whenever no read is issued
//   ram_rdata   in   RAM read data, valid one cycle after ram_rden
//   dump_valid  out  dump word available
//   dump_ready  in   consumer takes the word when valid & ready
//   dump_index  out  word index of dump_data
//   dump_data   out  RAM word
//   dump_last   out  high with the final word (index RAMDEPTH-1)
//   halt_pc     out  pc captured when the end of program was detected
//   done        out  dump complete, sticky until reset
// ---------------------------------------------------------------------------
module ram_dump_unit
  import riscv32s_pkg::*;
#(
  parameter int RAMDEPTH = RAMDEPTH_DEFAULT,
  parameter int AW       = addr_width(RAMDEPTH),
  parameter int PLW      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic [PLW-1:0]    prog_len,
  output logic              core_halt,
  output logic              ram_rden,
  output logic [AW-1:0]     ram_addr,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [AW-1:0]     dump_index,
  output logic [WORD_W-1:0] dump_data,
  output logic              dump_last,
  output logic [31:0]       halt_pc,
  output logic              done
);

  // Compare width covers both the 30-bit word PC and prog_len so that the
  // comparison stays unsigned and lossless for any PLW.
  localparam int CMP_W = (PLW > 30) ? PLW : 30;

  // The last word is found by comparison, so RAMDEPTH need not be 2**AW.
  localparam logic [AW-1:0] LAST_IDX = AW'(RAMDEPTH - 1);

  dump_state_e         state_q;
  logic [AW-1:0]       idx_q;
  logic                core_halt_q;
  logic [31:0]         halt_pc_q;
  logic                dump_valid_q;
  logic [AW-1:0]       dump_index_q;
  logic [WORD_W-1:0]   dump_data_q;
  logic                dump_last_q;
  logic                done_q;

  logic [CMP_W-1:0]    pc_word_d;
  logic [CMP_W-1:0]    prog_len_d;
  logic                end_hit_d;

  // Byte offset bits of pc play no part in the word-PC compare.
  logic                unused_pc_bits;
  assign unused_pc_bits = ^pc[1:0];

  assign pc_word_d  = CMP_W'(pc[31:2]);
  assign prog_len_d = CMP_W'(prog_len);
  assign end_hit_d  = (pc_word_d >= prog_len_d);

  // ---------------------------------------------------------------------
  // Dump FSM with its counter and registered outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      idx_q        <= '0;
      core_halt_q  <= 1'b0;
      halt_pc_q    <= '0;
      dump_valid_q <= 1'b0;
      dump_index_q <= '0;
      dump_data_q  <= '0;
      dump_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (end_hit_d) begin
            halt_pc_q   <= pc;
            core_halt_q <= 1'b1;
            state_q     <= ST_DRAIN;
          end
        end

        // One idle cycle lets a store that was in flight at the halt land
        // in RAM before we start reading it back.
        ST_DRAIN: begin
          state_q <= ST_ISSUE;
        end

        ST_ISSUE: begin
          state_q <= ST_CAPTURE;
        end

        // ram_rdata now holds the word requested in ISSUE.
        ST_CAPTURE: begin
          dump_data_q  <= ram_rdata;
          dump_index_q <= idx_q;
          dump_last_q  <= (idx_q == LAST_IDX);
          dump_valid_q <= 1'b1;
          state_q      <= ST_SEND;
        end

        // dump_* registers are untouched here until the handshake, which
        // keeps the offered word stable across any number of stall cycles.
        ST_SEND: begin
          if (dump_ready) begin
            dump_valid_q <= 1'b0;
            if (dump_last_q) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_ISSUE;
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_DONE;
        end

        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  // Read port is decoded straight from the state so the RAM sees the request
  // in the ISSUE cycle itself; the address is parked at 0 otherwise.
  assign ram_rden = (state_q == ST_ISSUE);
  assign ram_addr = ram_rden ? idx_q : '0;

  assign core_halt  = core_halt_q;
  assign halt_pc    = halt_pc_q;
  assign dump_valid = dump_valid_q;
  assign dump_index = dump_index_q;
  assign dump_data  = dump_data_q;
  assign dump_last  = dump_last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ram_dump_unit.sv
// ---------------------------------------------------------------------------
// tb_ram_dump_unit
// Randomised bench for ram_dump_unit with RAMDEPTH=8. A registered-read RAM
// model serves the dump port; the expected halt point comes from pc/4 vs
// prog_len and the expected stream is simply the RAM contents in order.
// ---------------------------------------------------------------------------
module tb_ram_dump_unit;

  localparam int RAMDEPTH = 8;
  localparam int AW       = 3;
  localparam int PLW      = 16;
  localparam int BUDGET   = 600;

  typedef struct {
    logic [AW-1:0] idx;
    logic [31:0]   data;
    logic          last;
  } word_t;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [31:0]    pc = '0;
  logic [PLW-1:0] prog_len = '0;
  logic           core_halt;
  logic           ram_rden;
  logic [AW-1:0]  ram_addr;
  logic [31:0]    ram_rdata = '0;
  logic           dump_valid;
  logic           dump_ready = 1'b0;
  logic [AW-1:0]  dump_index;
  logic [31:0]    dump_data;
  logic           dump_last;
  logic [31:0]    halt_pc;
  logic           done;

  logic [31:0]    mem [0:RAMDEPTH-1];

  int n_tests = 0;
  int n_fail  = 0;

  ram_dump_unit #(.RAMDEPTH(RAMDEPTH), .AW(AW), .PLW(PLW)) dut (
    .clock      (clock),
    .reset      (reset),
    .pc         (pc),
    .prog_len   (prog_len),
    .core_halt  (core_halt),
    .ram_rden   (ram_rden),
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_index (dump_index),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .halt_pc    (halt_pc),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Data RAM with registered read.
  always @(posedge clock) begin
    if (ram_rden) ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " core_halt"},  core_halt,  0);
    check({tag, " dump_valid"}, dump_valid, 0);
    check({tag, " dump_index"}, dump_index, 0);
    check({tag, " dump_data"},  dump_data,  0);
    check({tag, " dump_last"},  dump_last,  0);
    check({tag, " halt_pc"},    halt_pc,    0);
    check({tag, " done"},       done,       0);
    check({tag, " ram_rden"},   ram_rden,   0);
    check({tag, " ram_addr"},   ram_addr,   0);
  endtask

  task automatic fill_formula();
    for (int i = 0; i < RAMDEPTH; i++) mem[i] = 32'(i * 3 - 5);
  endtask

  task automatic fill_random();
    for (int i = 0; i < RAMDEPTH; i++) mem[i] = $urandom;
  endtask

  // ready_mode: 0 = always ready, 1 = ready one cycle in three, 2 = random.
  // abort_idx >= 0 asserts reset while that word is being offered.
  task automatic run_dump(input string name, input logic [PLW-1:0] plen,
                          input logic [31:0] pc0, input logic [31:0] pc_step,
                          input int ready_mode, input int abort_idx);
    word_t       exp_q[$];
    word_t       w;
    bit          halted = 0;
    bit          det;
    bit          hs;
    bit          prev_stall = 0;
    bit          finished = 0;
    bit          aborted = 0;
    int          halt_cyc = -1;
    int          first_valid_cyc = -1;
    int          done_cyc = -1;
    int          rden_cnt = 0;
    int          accepted = 0;
    logic [31:0] exp_halt_pc = '0;

    for (int i = 0; i < RAMDEPTH; i++) begin
      w.idx  = AW'(i);
      w.data = mem[i];
      w.last = (i == RAMDEPTH - 1);
      exp_q.push_back(w);
    end

    reset      = 1'b1;
    dump_ready = 1'b0;
    pc         = pc0;
    prog_len   = plen;
    tick();
    check({name, " reset"}, 0, 0 | {core_halt, dump_valid, done, ram_rden});
    reset = 1'b0;

    for (int cyc = 1; cyc <= BUDGET && !finished && !aborted; cyc++) begin
      det = !halted && ((pc / 4) >= 32'(plen));
      hs  = dump_valid && dump_ready;
      tick();

      if (det) begin
        halted      = 1;
        exp_halt_pc = pc;
        halt_cyc    = cyc;
        check({name, " halt_pc"}, halt_pc, exp_halt_pc);
      end
      check({name, " core_halt"}, core_halt, halted);

      if (hs) begin
        void'(exp_q.pop_front());
        accepted++;
        if (accepted == RAMDEPTH) done_cyc = cyc;
      end
      check({name, " done"}, done, done_cyc >= 0);

      if (ram_rden) begin
        check({name, " rd_addr"}, ram_addr, rden_cnt);
        check({name, " rd_order"}, rden_cnt, accepted);
        rden_cnt++;
      end else begin
        check({name, " addr_idle"}, ram_addr, 0);
      end

      if (dump_valid) begin
        if (first_valid_cyc < 0) begin
          first_valid_cyc = cyc;
          check({name, " latency"}, cyc - halt_cyc, 3);
        end
        if (exp_q.size() == 0) begin
          check({name, " extra_word"}, dump_valid, 0);
        end else begin
          check({name, " index"}, dump_index, exp_q[0].idx);
          check({name, " data"},  dump_data,  exp_q[0].data);
          check({name, " last"},  dump_last,  exp_q[0].last);
        end
        if (abort_idx >= 0 && int'(dump_index) == abort_idx) begin
          reset = 1'b1;
          tick();
          check_idle({name, " abort"});
          reset   = 1'b0;
          aborted = 1;
        end
      end else if (prev_stall) begin
        check({name, " hold_valid"}, dump_valid, 1);
      end

      if (done_cyc >= 0 && cyc >= done_cyc + 4) finished = 1;

      // After the halt the core inputs wander; they must be ignored.
      if (halted) begin
        pc       = $urandom;
        prog_len = PLW'($urandom);
      end else begin
        pc = pc + pc_step;
      end
      case (ready_mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = ((cyc % 3) == 0);
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      prev_stall = dump_valid && !dump_ready;
    end

    if (abort_idx >= 0) begin
      check({name, " abort_hit"}, aborted, 1);
    end else begin
      check({name, " finished"},   finished,    1);
      check({name, " rden_count"}, rden_cnt,    RAMDEPTH);
      check({name, " halt_final"}, halt_pc,     exp_halt_pc);
      $display("[TB] %s: halt_pc=0x%0h words=%0d reads=%0d", name, halt_pc, accepted, rden_cnt);
    end
  endtask

  initial begin
    fill_formula();
    run_dump("t1_plen11", 16'd11, 32'd0, 32'd4, 0, -1);
    check("t1_halt_pc_44", halt_pc, 32'd44);

    fill_random();
    run_dump("t3_stall", PLW'($urandom_range(1, 12)), 32'd0, 32'd4, 1, -1);

    fill_random();
    run_dump("t4_plen0", 16'd0, 32'd0, 32'd4, 2, -1);

    fill_random();
    run_dump("t5_abort", 16'd5, 32'd0, 32'd4, 2, 4);
    run_dump("t5_rerun", 16'd5, 32'd0, 32'd4, 2, -1);

    fill_random();
    run_dump("t6_unsigned", 16'hFFFF, 32'hFFFF_FFFC, 32'd0, 2, -1);

    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_dump("rand", PLW'($urandom_range(0, 20)), 32'd0, 32'd4, 2, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
